// File: rtl/vend_ctrl.sv
// Vending machine controller: collects coins, vends at PRICE, pays change in
// dimes then nickels through a handshaked hopper, refunds on cancel or idle timeout.
module vend_ctrl #(
    parameter int unsigned PRICE   = 20,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    input  logic       cancel_i,
    input  logic       coin_ack_i,
    output logic [5:0] deposit_o,
    output logic       soda_o,
    output logic       dime_out_o,
    output logic       nickel_out_o,
    output logic       coin_reject_o,
    output logic       busy_o
);

    localparam int unsigned CW = 6;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
    localparam logic [CW-1:0] NICKEL_C  = CW'(5);
    localparam logic [CW-1:0] DIME_C    = CW'(10);
    localparam logic [CW-1:0] QUARTER_C = CW'(25);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_credit;
    logic [TW-1:0] r_timer;
    logic          r_soda;
    logic          r_dime_out;
    logic          r_nickel_out;
    logic          r_reject;
    logic          r_busy;

    logic          w_any_coin;
    logic          w_multi;
    logic [CW-1:0] w_coin_val;
    logic [CW:0]   w_sum;
    logic          w_refund;
    logic [CW-1:0] w_vend_left;
    logic          w_ack;
    logic [CW-1:0] w_ack_val;
    logic [CW-1:0] w_change_left;

    // Coin decode: highest-value coin wins when several pulse together
    assign w_any_coin = nickel_i | dime_i | quarter_i;
    assign w_multi    = (nickel_i & dime_i) | (nickel_i & quarter_i) | (dime_i & quarter_i);
    assign w_coin_val = quarter_i ? QUARTER_C :
                        dime_i    ? DIME_C    :
                        nickel_i  ? NICKEL_C  : '0;
    assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};

    // Cancel and idle expiry both refund, and only while collecting
    assign w_refund   = (r_state == S_COLLECT) && (cancel_i || (r_timer == TMO_LAST));

    assign w_vend_left   = r_credit - PRICE_C;
    assign w_ack         = coin_ack_i && (r_dime_out || r_nickel_out);
    assign w_ack_val     = r_dime_out ? DIME_C : NICKEL_C;
    assign w_change_left = r_credit - w_ack_val;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_credit     <= '0;
            r_timer      <= '0;
            r_soda       <= 1'b0;
            r_dime_out   <= 1'b0;
            r_nickel_out <= 1'b0;
            r_reject     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_soda   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_refund) begin
                        r_state      <= S_CHANGE;
                        r_busy       <= 1'b1;
                        r_reject     <= w_any_coin;
                        r_timer      <= '0;
                        r_dime_out   <= (r_credit >= DIME_C);
                        r_nickel_out <= (r_credit <  DIME_C);
                    end else if (w_any_coin) begin
                        r_credit <= w_sum[CW-1:0];
                        r_reject <= w_multi;
                        r_timer  <= '0;
                        if (w_sum >= {1'b0, PRICE_C}) begin
                            r_state <= S_VEND;
                            r_soda  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end else if (r_state == S_COLLECT) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_VEND: begin
                    r_reject <= w_any_coin;
                    r_credit <= w_vend_left;
                    if (w_vend_left != '0) begin
                        r_state      <= S_CHANGE;
                        r_dime_out   <= (w_vend_left >= DIME_C);
                        r_nickel_out <= (w_vend_left <  DIME_C);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_CHANGE: begin
                    r_reject <= w_any_coin;
                    if (w_ack) begin
                        r_credit <= w_change_left;
                        if (w_change_left == '0) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_dime_out   <= 1'b0;
                            r_nickel_out <= 1'b0;
                        end else begin
                            r_dime_out   <= (w_change_left >= DIME_C);
                            r_nickel_out <= (w_change_left <  DIME_C);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign deposit_o     = r_credit;
    assign soda_o        = r_soda;
    assign dime_out_o    = r_dime_out;
    assign nickel_out_o  = r_nickel_out;
    assign coin_reject_o = r_reject;
    assign busy_o        = r_busy;

endmodule
